// File: rtl/mac_array_pkg.sv
// Shared defaults and saturating arithmetic helpers for the multi-lane MAC engine.
// Helpers work on a wide signed scratch type so any lane width up to CALC_W fits.
package mac_array_pkg;

    localparam int DEF_DWIDTH = 16;
    localparam int DEF_FRAC   = 8;
    localparam int DEF_GUARD  = 8;
    localparam int DEF_AWIDTH = 2 * DEF_DWIDTH + DEF_GUARD;

    localparam int CALC_W = 128;

    typedef logic signed [CALC_W-1:0] calc_t;

    function automatic calc_t lim_hi(input int width);
        calc_t one;
        one = calc_t'(1);
        return (one <<< (width - 1)) - one;
    endfunction

    function automatic calc_t lim_lo(input int width);
        return -lim_hi(width) - calc_t'(1);
    endfunction

    // Saturating signed add clamped to a width-bit two's complement range.
    function automatic calc_t sat_add(
        input  calc_t a,
        input  calc_t b,
        input  int    width,
        output logic  ovf
    );
        calc_t s;
        s   = a + b;
        ovf = 1'b0;
        if (s > lim_hi(width)) begin
            s   = lim_hi(width);
            ovf = 1'b1;
        end else if (s < lim_lo(width)) begin
            s   = lim_lo(width);
            ovf = 1'b1;
        end
        return s;
    endfunction

    // Drop frac bits rounding half toward +inf, then clamp to width bits.
    function automatic calc_t round_sat(
        input  calc_t a,
        input  int    frac,
        input  int    width,
        output logic  ovf
    );
        calc_t r;
        r   = (a + (calc_t'(1) <<< (frac - 1))) >>> frac;
        ovf = 1'b0;
        if (r > lim_hi(width)) begin
            r   = lim_hi(width);
            ovf = 1'b1;
        end else if (r < lim_lo(width)) begin
            r   = lim_lo(width);
            ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_array_lane.sv
// One MAC lane: product register, saturating accumulator with sticky overflow,
// and the rounded / clamped / ReLU output register.
module mac_lane
    import mac_array_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int FRAC   = DEF_FRAC,
    parameter int GUARD  = DEF_GUARD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_en,
    input  logic              acc_en,
    input  logic              acc_first,
    input  logic              out_en,
    input  logic              relu,
    input  logic [DWIDTH-1:0] x,
    input  logic [DWIDTH-1:0] w,
    input  logic [DWIDTH-1:0] bias,
    output logic [DWIDTH-1:0] y,
    output logic              ovf
);

    localparam int AWIDTH = 2 * DWIDTH + GUARD;

    logic signed [2*DWIDTH-1:0] x_ext;
    logic signed [2*DWIDTH-1:0] w_ext;
    logic signed [2*DWIDTH-1:0] prod_q;
    logic signed [DWIDTH-1:0]   bias_q;

    logic signed [AWIDTH-1:0]   acc_q;
    logic signed [AWIDTH-1:0]   acc_d;
    logic                       acc_ovf_q;
    logic                       add_ovf;

    calc_t                      acc_base;
    calc_t                      prod_ext;

    logic signed [DWIDTH-1:0]   rounded;
    logic                       rnd_ovf;
    logic [DWIDTH-1:0]          y_d;

    assign x_ext = {{DWIDTH{x[DWIDTH-1]}}, x};
    assign w_ext = {{DWIDTH{w[DWIDTH-1]}}, w};

    // S2: full-precision product; bias travels alongside so it meets the first term in S3.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            bias_q <= '0;
        end else if (prod_en) begin
            prod_q <= x_ext * w_ext;
            bias_q <= bias;
        end
    end

    always_comb begin
        prod_ext = calc_t'(prod_q);
        acc_base = calc_t'(acc_q);
        if (acc_first) begin
            acc_base = calc_t'(bias_q) <<< FRAC;
        end
        acc_d = AWIDTH'(sat_add(acc_base, prod_ext, AWIDTH, add_ovf));
    end

    // S3: a first term restarts both the sum and its sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            acc_ovf_q <= 1'b0;
        end else if (acc_en) begin
            acc_q     <= acc_d;
            acc_ovf_q <= (acc_first ? 1'b0 : acc_ovf_q) | add_ovf;
        end
    end

    always_comb begin
        rounded = DWIDTH'(round_sat(calc_t'(acc_q), FRAC, DWIDTH, rnd_ovf));
        y_d     = rounded;
        if (relu && rounded[DWIDTH-1]) begin
            y_d = '0;
        end
    end

    // S4: ReLU clamping is not an overflow; only saturation reports one.
    always_ff @(posedge clk) begin
        if (rst) begin
            y   <= '0;
            ovf <= 1'b0;
        end else if (out_en) begin
            y   <= y_d;
            ovf <= acc_ovf_q | rnd_ovf;
        end
    end

endmodule

// File: rtl/mac_array.sv
// Multi-lane fixed-point MAC: shared activation against per-lane weights,
// four-stage pipeline (input reg, product, accumulate, round/saturate/ReLU).
module mac_array
    import mac_array_pkg::*;
#(
    parameter int DWIDTH = DEF_DWIDTH,
    parameter int FRAC   = DEF_FRAC,
    parameter int LANES  = 8,
    parameter int GUARD  = DEF_GUARD
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic                    mode_relu,
    input  logic [DWIDTH-1:0]       x,
    input  logic [LANES*DWIDTH-1:0] w,
    input  logic [LANES*DWIDTH-1:0] bias,
    output logic                    out_valid,
    output logic [LANES*DWIDTH-1:0] y,
    output logic [LANES-1:0]        ovf
);

    // Handshake: in_valid alone qualifies a term and in_first/in_last; there is no
    // ready, a term is accepted every valid cycle. out_valid is a one-cycle pulse
    // with no backpressure, and y/ovf hold until the next pulse.

    logic                    s1_valid;
    logic                    s1_first;
    logic                    s1_last;
    logic                    s1_relu;
    logic [DWIDTH-1:0]       s1_x;
    logic [LANES*DWIDTH-1:0] s1_w;
    logic [LANES*DWIDTH-1:0] s1_bias;

    logic                    s2_valid;
    logic                    s2_first;
    logic                    s2_last;
    logic                    s2_relu;

    logic                    s3_last;
    logic                    s3_relu;

    // S1: flags are pre-qualified by in_valid so bubbles cannot leak first/last.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_relu  <= 1'b0;
            s1_x     <= '0;
            s1_w     <= '0;
            s1_bias  <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_first <= in_valid & in_first;
            s1_last  <= in_valid & in_last;
            s1_relu  <= mode_relu;
            if (in_valid) begin
                s1_x    <= x;
                s1_w    <= w;
                s1_bias <= bias;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_first  <= 1'b0;
            s2_last   <= 1'b0;
            s2_relu   <= 1'b0;
            s3_last   <= 1'b0;
            s3_relu   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            s2_valid  <= s1_valid;
            s2_first  <= s1_first;
            s2_last   <= s1_last;
            s2_relu   <= s1_relu;
            s3_last   <= s2_valid & s2_last;
            s3_relu   <= s2_relu;
            out_valid <= s3_last;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mac_lane #(
            .DWIDTH (DWIDTH),
            .FRAC   (FRAC),
            .GUARD  (GUARD)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .prod_en   (s1_valid),
            .acc_en    (s2_valid),
            .acc_first (s2_first),
            .out_en    (s3_last),
            .relu      (s3_relu),
            .x         (s1_x),
            .w         (s1_w[k*DWIDTH +: DWIDTH]),
            .bias      (s1_bias[k*DWIDTH +: DWIDTH]),
            .y         (y[k*DWIDTH +: DWIDTH]),
            .ovf       (ovf[k])
        );
    end

endmodule

// File: tb/tb_mac_array.sv
// Directed bench for mac_array: single-term vector table plus multi-cycle sequences,
// checked against an expected-output queue with latency and hold checks.
`timescale 1ns/1ps
module tb_mac_array;

    localparam int DW = 16;
    localparam int FR = 8;
    localparam int LN = 4;
    localparam int RW = LN * DW + LN;

    typedef struct packed {
        logic [DW-1:0]         x;
        logic [LN-1:0][DW-1:0] w;
        logic [LN-1:0][DW-1:0] b;
        logic                  relu;
        logic [LN-1:0][DW-1:0] ey;
        logic [LN-1:0]         eovf;
    } vec_t;

    localparam int NVEC = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_first = 1'b0;
    logic                in_last = 1'b0;
    logic                mode_relu = 1'b0;
    logic [DW-1:0]       x = '0;
    logic [LN*DW-1:0]    w = '0;
    logic [LN*DW-1:0]    bias = '0;
    logic                out_valid;
    logic [LN*DW-1:0]    y;
    logic [LN-1:0]       ovf;

    int                  checks = 0;
    int                  failures = 0;
    int                  cyc = 0;
    logic                rst_q = 1'b1;
    logic [RW-1:0]       exp_q[$];
    int                  exp_cyc_q[$];
    logic [LN*DW-1:0]    held_y = '0;
    logic [LN-1:0]       held_ovf = '0;
    vec_t                vecs[NVEC];

    mac_array #(
        .DWIDTH (DW),
        .FRAC   (FR),
        .LANES  (LN),
        .GUARD  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .mode_relu (mode_relu),
        .x         (x),
        .w         (w),
        .bias      (bias),
        .out_valid (out_valid),
        .y         (y),
        .ovf       (ovf)
    );

    // clock / reset bookkeeping
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard / monitor
    always @(negedge clk) begin
        logic [RW-1:0] e;
        int            c;
        if (rst_q) begin
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_y", 64'(y), 64'(0));
            check("rst_ovf", 64'(ovf), 64'(0));
            held_y   = '0;
            held_ovf = '0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got y=%0h ovf=%0h with nothing expected", y, ovf);
            end else begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                check("y", 64'(y), 64'(e[RW-1:LN]));
                check("ovf", 64'(ovf), 64'(e[LN-1:0]));
                check("latency", 64'(cyc), 64'(c + 4));
                held_y   = e[RW-1:LN];
                held_ovf = e[LN-1:0];
            end
        end else begin
            check("hold_y", 64'(y), 64'(held_y));
            check("hold_ovf", 64'(ovf), 64'(held_ovf));
        end
    end

    // driver tasks
    task automatic randomize_inputs();
        in_first  = 1'($urandom_range(0, 1));
        in_last   = 1'($urandom_range(0, 1));
        mode_relu = 1'($urandom_range(0, 1));
        x         = 16'($urandom_range(0, 65535));
        w         = {$urandom(), $urandom()};
        bias      = {$urandom(), $urandom()};
    endtask

    task automatic term(input logic f, input logic l, input logic r, input logic [DW-1:0] xv,
                        input logic [LN*DW-1:0] wv, input logic [LN*DW-1:0] bv);
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_first  = f;
        in_last   = l;
        mode_relu = r;
        x         = xv;
        w         = wv;
        bias      = bv;
    endtask

    task automatic bubble();
        @(negedge clk);
        rst      = 1'b0;
        randomize_inputs();
        in_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        randomize_inputs();
        in_valid = 1'b1;
        in_last  = 1'b1;
    endtask

    task automatic expect_out(input logic [LN*DW-1:0] ey, input logic [LN-1:0] eo);
        exp_q.push_back({ey, eo});
        exp_cyc_q.push_back(cyc);
    endtask

    // sum of x=w=i*256 for i=0..4 on lane 0, with optional bubbles between terms
    task automatic basic_sum(input logic gaps);
        logic [DW-1:0] v;
        logic [DW-1:0] h;
        for (int i = 0; i <= 4; i++) begin
            v = 16'(i * 256);
            h = 16'(i * 128);
            term(i == 0, i == 4, 1'b0, v, {h, 16'h0000, 16'(-v), v},
                 {16'h0000, 16'h0100, 16'h0000, 16'h0000});
            if (gaps && i != 4) begin
                repeat ($urandom_range(0, 3)) bubble();
            end
        end
        expect_out({16'h0F00, 16'h0100, 16'hE200, 16'h1E00}, 4'b0000);
    endtask

    task automatic in_range_sum();
        term(1'b1, 1'b0, 1'b0, 16'h0100, {LN{16'h0100}}, '0);
        term(1'b0, 1'b1, 1'b0, 16'h0100, {LN{16'h0100}}, '0);
        expect_out({LN{16'h0200}}, 4'b0000);
    endtask

    initial begin
        vecs[0] = '{x: 16'h0300, w: {16'h0000, 16'h0080, 16'h0100, 16'hFF00},
                    b: {16'h8000, 16'h0100, 16'h0000, 16'h0200}, relu: 1'b0,
                    ey: {16'h8000, 16'h0280, 16'h0300, 16'hFF00}, eovf: 4'b0000};
        vecs[1] = '{x: 16'h0300, w: {16'h0000, 16'h0080, 16'h0100, 16'hFF00},
                    b: {16'h8000, 16'h0100, 16'h0000, 16'h0200}, relu: 1'b1,
                    ey: {16'h0000, 16'h0280, 16'h0300, 16'h0000}, eovf: 4'b0000};
        vecs[2] = '{x: 16'h0001, w: {16'hFF7F, 16'h007F, 16'hFF80, 16'h0080},
                    b: '0, relu: 1'b0,
                    ey: {16'hFFFF, 16'h0000, 16'h0000, 16'h0001}, eovf: 4'b0000};
        vecs[3] = '{x: 16'h7FFF, w: {16'h0000, 16'h0001, 16'h8000, 16'h7FFF},
                    b: {16'h7FFF, 16'h0000, 16'h0000, 16'h0000}, relu: 1'b0,
                    ey: {16'h7FFF, 16'h0080, 16'h8000, 16'h7FFF}, eovf: 4'b0011};
        vecs[4] = '{x: 16'h7FFF, w: {16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF},
                    b: '0, relu: 1'b1,
                    ey: {16'h0000, 16'h0000, 16'h0000, 16'h7FFF}, eovf: 4'b0011};
        vecs[5] = '{x: 16'h0100, w: {16'h7FFF, 16'h0040, 16'hFE00, 16'h0100},
                    b: {16'h7FFF, 16'h0000, 16'h0080, 16'hFF00}, relu: 1'b0,
                    ey: {16'h7FFF, 16'h0040, 16'hFE80, 16'h0000}, eovf: 4'b1000};

        // reset with random inputs for two edges
        rst = 1'b1;
        randomize_inputs();
        in_valid = 1'b1;
        @(negedge clk);
        randomize_inputs();
        in_valid = 1'b1;
        in_last  = 1'b1;
        bubble();
        bubble();

        // single-term table, back to back
        for (int i = 0; i < NVEC; i++) begin
            term(1'b1, 1'b1, vecs[i].relu, vecs[i].x, vecs[i].w, vecs[i].b);
            expect_out(vecs[i].ey, vecs[i].eovf);
        end
        repeat (3) bubble();

        basic_sum(1'b0);
        basic_sum(1'b1);
        basic_sum(1'b0);
        repeat (2) bubble();

        // output saturation, then a clean sum must clear ovf
        for (int i = 0; i < 4; i++) begin
            term(i == 0, i == 3, 1'b0, 16'h7F00, {16'h0001, 16'h0000, 16'h8100, 16'h7F00}, '0);
        end
        expect_out({16'h01FC, 16'h0000, 16'h8000, 16'h7FFF}, 4'b0011);
        in_range_sum();

        // accumulator saturation: 520 products of 2^30 exceed the 40-bit range
        for (int i = 0; i < 520; i++) begin
            term(i == 0, i == 519, 1'b0, 16'h8000, {16'h0000, 16'h0000, 16'h7FFF, 16'h8000}, '0);
        end
        expect_out({16'h0000, 16'h0000, 16'h8000, 16'h7FFF}, 4'b0011);
        in_range_sum();
        repeat (2) bubble();

        // reset mid-sum flushes the in-flight last term
        term(1'b1, 1'b0, 1'b0, 16'h0100, {LN{16'h0100}}, {LN{16'h1000}});
        term(1'b0, 1'b0, 1'b0, 16'h0100, {LN{16'h0100}}, '0);
        term(1'b0, 1'b1, 1'b0, 16'h0100, {LN{16'h0100}}, '0);
        pulse_rst();
        // last with no open sum accumulates onto the cleared accumulator
        term(1'b0, 1'b1, 1'b0, 16'h0100, {LN{16'h0300}}, {$urandom(), $urandom()});
        expect_out({LN{16'h0300}}, 4'b0000);

        // a second first discards the open sum
        term(1'b1, 1'b0, 1'b0, 16'h0100, {LN{16'h0100}}, {LN{16'h1000}});
        term(1'b0, 1'b0, 1'b0, 16'h0100, {LN{16'h0100}}, '0);
        term(1'b1, 1'b0, 1'b0, 16'h0100, {LN{16'h0100}}, {LN{16'h0100}});
        term(1'b0, 1'b1, 1'b0, 16'h0200, {LN{16'h0100}}, {$urandom(), $urandom()});
        expect_out({LN{16'h0400}}, 4'b0000);
        bubble();

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        check("drain_pending", 64'(exp_q.size()), 64'(0));
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
